// File: rtl/g3f_seq_ctrl.sv
// g3f_seq_ctrl: run/stop sequencer for the g3f three-phase Johnson ring.
// Each step advances {Qa,Qb,Qc} around a six-state ring, forward or reverse.
// Step period is DIV+1 clocks. A run is either NSTEP steps or continuous (NSTEP=0).
// Handshake: none. START and STOP are levels sampled on every rising edge of SE.
// STEP and DONE are single-cycle pulses that appear in the cycle after their edge.
// All outputs come straight from flops, so the FSM state is visible on BUSY.
module g3f_seq_ctrl #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             SE,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             DIR,
    input  logic [DIV_W-1:0] DIV,
    input  logic [CNT_W-1:0] NSTEP,
    output logic             Qa,
    output logic             Qb,
    output logic             Qc,
    output logic             P2,
    output logic             BUSY,
    output logic             STEP,
    output logic             DONE,
    output logic [CNT_W-1:0] LEFT
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [2:0]       phase, phase_n;
    logic [DIV_W-1:0] presc, presc_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [CNT_W-1:0] left, left_n;
    logic             cont, cont_n;
    logic             step_q, step_n;
    logic             done_q, done_n;
    logic             busy_q, busy_n;
    logic             p2_q;

    // One step around the Johnson ring. 010 and 101 cannot be reached from
    // reset, but if they ever appear the ring is pulled back to 000.
    function automatic logic [2:0] ring_next(input logic [2:0] cur, input logic fwd);
        logic [2:0] nxt;
        nxt = 3'b000;
        case (cur)
            3'b000: nxt = fwd ? 3'b100 : 3'b001;
            3'b100: nxt = fwd ? 3'b110 : 3'b000;
            3'b110: nxt = fwd ? 3'b111 : 3'b100;
            3'b111: nxt = fwd ? 3'b011 : 3'b110;
            3'b011: nxt = fwd ? 3'b001 : 3'b111;
            3'b001: nxt = fwd ? 3'b000 : 3'b011;
            default: nxt = 3'b000;
        endcase
        return nxt;
    endfunction

    // State register: FSM state, timing counters, phase and registered outputs.
    always_ff @(posedge SE or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            phase  <= 3'b000;
            presc  <= '0;
            div_q  <= '0;
            left   <= '0;
            cont   <= 1'b0;
            step_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            p2_q   <= 1'b1;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            presc  <= presc_n;
            div_q  <= div_n;
            left   <= left_n;
            cont   <= cont_n;
            step_q <= step_n;
            done_q <= done_n;
            busy_q <= busy_n;
            p2_q   <= ~phase_n[1];
        end
    end

    // Next-state logic. STOP takes priority over a due step, so an abort never
    // moves the phase on its way back to IDLE.
    always_comb begin
        state_n = state;
        phase_n = phase;
        presc_n = presc;
        div_n   = div_q;
        left_n  = left;
        cont_n  = cont;
        step_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (START && !STOP) begin
                    state_n = S_RUN;
                    presc_n = DIV;
                    div_n   = DIV;
                    left_n  = NSTEP;
                    cont_n  = (NSTEP == '0);
                end
            end
            S_RUN: begin
                if (STOP) begin
                    state_n = S_IDLE;
                    left_n  = '0;
                end else if (presc != '0) begin
                    presc_n = presc - DIV_W'(1);
                end else begin
                    phase_n = ring_next(phase, DIR);
                    presc_n = div_q;
                    step_n  = 1'b1;
                    if (!cont) begin
                        left_n = left - CNT_W'(1);
                        if (left == CNT_W'(1)) begin
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        busy_n = (state_n == S_RUN);
    end

    // Output mapping: every output is taken directly from a flop.
    always_comb begin
        Qa   = phase[2];
        Qb   = phase[1];
        Qc   = phase[0];
        P2   = p2_q;
        BUSY = busy_q;
        STEP = step_q;
        DONE = done_q;
        LEFT = left;
    end

endmodule

// File: tb/tb_g3f_seq_ctrl.sv
// Testbench for g3f_seq_ctrl: reset checks, table-driven runs, hand-written
// corner sequences, and random stimulus against a ring-index reference model.
module tb_g3f_seq_ctrl;

    logic       SE = 1'b0;
    logic       RST;
    logic       START;
    logic       STOP;
    logic       DIR;
    logic [7:0] DIV;
    logic [7:0] NSTEP;
    logic       Qa, Qb, Qc, P2, BUSY, STEP, DONE;
    logic [7:0] LEFT;

    int checks = 0;
    int errors = 0;

    g3f_seq_ctrl #(.DIV_W(8), .CNT_W(8)) dut (
        .SE(SE), .RST(RST), .START(START), .STOP(STOP), .DIR(DIR),
        .DIV(DIV), .NSTEP(NSTEP),
        .Qa(Qa), .Qb(Qb), .Qc(Qc), .P2(P2), .BUSY(BUSY),
        .STEP(STEP), .DONE(DONE), .LEFT(LEFT)
    );

    // Clock.
    always #5 SE = ~SE;

    // Forward ring order; reverse walks it backwards.
    logic [2:0] ring [6] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001};

    typedef struct {
        logic       start;
        logic       stop;
        logic       dir;
        logic [7:0] div;
        logic [7:0] nstep;
        logic [2:0] q;
        logic       busy;
        logic       step;
        logic       done;
        logic [7:0] left;
    } vec_t;

    vec_t tab [12];

    // Reference model state.
    bit m_run;
    bit m_cont;
    int m_wait;
    int m_div;
    int m_left;
    int m_idx;
    bit e_step;
    bit e_done;

    task automatic tick();
        @(posedge SE);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] q, input logic busy,
                             input logic step, input logic done, input logic [7:0] left);
        chk({tag, " phase"}, {29'd0, Qa, Qb, Qc}, {29'd0, q});
        chk({tag, " P2"}, {31'd0, P2}, {31'd0, ~q[1]});
        chk({tag, " BUSY"}, {31'd0, BUSY}, {31'd0, busy});
        chk({tag, " STEP"}, {31'd0, STEP}, {31'd0, step});
        chk({tag, " DONE"}, {31'd0, DONE}, {31'd0, done});
        chk({tag, " LEFT"}, {24'd0, LEFT}, {24'd0, left});
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            START = tab[i].start;
            STOP  = tab[i].stop;
            DIR   = tab[i].dir;
            DIV   = tab[i].div;
            NSTEP = tab[i].nstep;
            tick();
            check_out($sformatf("tab%0d", i), tab[i].q, tab[i].busy,
                      tab[i].step, tab[i].done, tab[i].left);
        end
        START = 1'b0;
        STOP  = 1'b0;
    endtask

    // One clock of the behavioural model, using the inputs about to be sampled.
    task automatic model_edge();
        e_step = 1'b0;
        e_done = 1'b0;
        if (!m_run) begin
            if (START && !STOP) begin
                m_run  = 1'b1;
                m_div  = int'(DIV);
                m_wait = int'(DIV);
                m_left = int'(NSTEP);
                m_cont = (NSTEP == 8'd0);
            end
        end else if (STOP) begin
            m_run  = 1'b0;
            m_left = 0;
        end else if (m_wait > 0) begin
            m_wait--;
        end else begin
            m_idx  = DIR ? (m_idx + 1) % 6 : (m_idx + 5) % 6;
            m_wait = m_div;
            e_step = 1'b1;
            if (!m_cont) begin
                m_left--;
                if (m_left == 0) begin
                    m_run  = 1'b0;
                    e_done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        // Reverse run DIV=0 from 000, with a START+STOP collision first and a
        // START/DIV/NSTEP change mid-run that must be ignored.
        tab[0]  = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd3, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0};
        tab[1]  = '{1'b1, 1'b0, 1'b0, 8'd0, 8'd3, 3'b000, 1'b1, 1'b0, 1'b0, 8'd3};
        tab[2]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 3'b001, 1'b1, 1'b1, 1'b0, 8'd2};
        tab[3]  = '{1'b1, 1'b0, 1'b0, 8'd5, 8'd9, 3'b011, 1'b1, 1'b1, 1'b0, 8'd1};
        tab[4]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 3'b111, 1'b0, 1'b1, 1'b1, 8'd0};
        tab[5]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 3'b111, 1'b0, 1'b0, 1'b0, 8'd0};
        // DIR flip mid-run, DIV=0, NSTEP=4, from 000.
        tab[6]  = '{1'b1, 1'b0, 1'b1, 8'd0, 8'd4, 3'b000, 1'b1, 1'b0, 1'b0, 8'd4};
        tab[7]  = '{1'b0, 1'b0, 1'b1, 8'd0, 8'd4, 3'b100, 1'b1, 1'b1, 1'b0, 8'd3};
        tab[8]  = '{1'b0, 1'b0, 1'b1, 8'd0, 8'd4, 3'b110, 1'b1, 1'b1, 1'b0, 8'd2};
        tab[9]  = '{1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 3'b100, 1'b1, 1'b1, 1'b0, 8'd1};
        tab[10] = '{1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 3'b000, 1'b0, 1'b1, 1'b1, 8'd0};
        tab[11] = '{1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0};

        // Reset, then idle for 10 clocks.
        RST = 1'b1; START = 1'b0; STOP = 1'b0; DIR = 1'b1; DIV = 8'd0; NSTEP = 8'd0;
        tick();
        tick();
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out($sformatf("idle%0d", i), 3'b000, 1'b0, 1'b0, 1'b0, 8'd0);
        end

        // Counted forward run, DIV=2, NSTEP=6; later DIV/NSTEP edits are ignored.
        DIV = 8'd2; NSTEP = 8'd6; DIR = 1'b1; START = 1'b1;
        tick();
        check_out("fwd0", 3'b000, 1'b1, 1'b0, 1'b0, 8'd6);
        START = 1'b0; DIV = 8'd7; NSTEP = 8'd1;
        for (int e = 1; e <= 20; e++) begin
            int n;
            n = (e / 3 > 6) ? 6 : e / 3;
            tick();
            check_out($sformatf("fwd%0d", e), ring[n % 6], (e < 18),
                      (e % 3 == 0) && (e <= 18), (e == 18), 8'(6 - n));
        end

        // Reverse run and START+STOP collision from table.
        run_table(0, 5);

        // Async reset mid-run while phase = 111.
        DIV = 8'd3; NSTEP = 8'd0; START = 1'b1;
        tick();
        check_out("ar_run", 3'b111, 1'b1, 1'b0, 1'b0, 8'd0);
        START = 1'b0;
        tick();
        #2 RST = 1'b1;
        #1 check_out("ar_async", 3'b000, 1'b0, 1'b0, 1'b0, 8'd0);
        #1 RST = 1'b0;
        tick();
        check_out("ar_after", 3'b000, 1'b0, 1'b0, 1'b0, 8'd0);

        // DIR flip run starting from 000 after the reset.
        run_table(6, 11);

        // STOP on the edge where the prescaler is due: no step, no DONE.
        DIV = 8'd1; NSTEP = 8'd0; DIR = 1'b1; START = 1'b1;
        tick();
        check_out("stop0", 3'b000, 1'b1, 1'b0, 1'b0, 8'd0);
        START = 1'b0;
        tick();
        check_out("stop1", 3'b000, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        check_out("stop2", 3'b100, 1'b1, 1'b1, 1'b0, 8'd0);
        tick();
        check_out("stop3", 3'b100, 1'b1, 1'b0, 1'b0, 8'd0);
        STOP = 1'b1;
        tick();
        check_out("stop4", 3'b100, 1'b0, 1'b0, 1'b0, 8'd0);
        STOP = 1'b0;
        tick();
        check_out("stop5", 3'b100, 1'b0, 1'b0, 1'b0, 8'd0);

        // Random stimulus against the model, starting from a fresh reset.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        m_run = 1'b0; m_cont = 1'b0; m_wait = 0; m_div = 0; m_left = 0; m_idx = 0;
        for (int c = 0; c < 600; c++) begin
            START = ($urandom_range(0, 2) == 0);
            STOP  = ($urandom_range(0, 24) == 0);
            DIR   = 1'($urandom_range(0, 1));
            DIV   = 8'($urandom_range(0, 3));
            NSTEP = 8'($urandom_range(0, 5));
            model_edge();
            tick();
            check_out($sformatf("rnd%0d", c), ring[m_idx], m_run, e_step, e_done,
                      8'(m_cont ? 0 : m_left));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
